// File: rtl/dm_ctrl.sv
// dm_ctrl -- data-memory access sequencer between the MEM stage and the
// shared data bus. Accepts one load/store at a time, derives byte lane
// enables from the access width and address low bits, runs a registered
// request/acknowledge bus transaction while stalling the pipeline, and
// returns lane-aligned, sign/zero-extended load data. A watchdog aborts a
// transaction that sees no bus_ack within TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT      max BUS-state cycles without bus_ack (1..255)
// Optional build macro:
//   DM_ALIGN_CHECK_EN  misaligned H/W accesses are illegal (adel/ades)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req, we, besel,          MEM-stage request, direction, width,
//   ld_unsigned, addr, wdata extension mode, byte address, store data
//   stall, done, rdata       pipeline freeze, completion pulse, load data
//   adel, ades, bus_err      load/store address error, watchdog abort
//   bus_req, bus_we,         bus request, write, word address,
//   bus_addr, bus_be,        lane enables, replicated store data
//   bus_wdata
//   bus_rdata, bus_ack       bus read word, bus completion

module dm_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  besel,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [1:0] BESEL_W = 2'b00;
  localparam logic [1:0] BESEL_H = 2'b01;
  localparam logic [1:0] BESEL_B = 2'b10;

  // Last watchdog value before abort: counter starts at 0 in the first BUS
  // cycle, so hitting TIMEOUT-1 without ack ends the TIMEOUT-th cycle.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  besel_q, besel_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wd_q, wd_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  // Request decode (combinational on live MEM-stage inputs)
  logic        legal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  always_comb begin
    legal     = 1'b1;
    be_new    = '0;
    wdata_new = wdata;
    case (besel)
      BESEL_W: begin
        be_new = 4'b1111;
`ifdef DM_ALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) legal = 1'b0;
`endif
      end
      BESEL_H: begin
        be_new    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata[15:0]}};
`ifdef DM_ALIGN_CHECK_EN
        if (addr[0]) legal = 1'b0;
`endif
      end
      BESEL_B: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      default: legal = 1'b0;
    endcase
  end

  // Read-lane select and extension from the latched access fields
  logic [31:0] ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = bus_rdata[{addr_q[1], 4'b0000} +: 16];
    case (besel_q)
      BESEL_B: ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      BESEL_H: ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      besel_q <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      besel_q <= besel_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    besel_d = besel_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    wd_d    = wd_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req && legal) begin
          we_d    = we;
          besel_d = besel;
          uns_d   = ld_unsigned;
          addr_d  = addr;
          be_d    = be_new;
          wdata_d = wdata_new;
          wd_d    = '0;
          err_d   = 1'b0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // An ack in the final watchdog cycle still completes normally.
        if (bus_ack) begin
          rdata_d = we_q ? '0 : ld_ext;
          state_d = S_DONE;
        end else if (wd_q == WD_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic in_idle, in_bus, in_done;
  assign in_idle = (state_q == S_IDLE);
  assign in_bus  = (state_q == S_BUS);
  assign in_done = (state_q == S_DONE);

  assign stall     = (in_idle & req & legal) | in_bus;
  assign done      = in_done;
  assign bus_err   = in_done & err_q;
  assign rdata     = rdata_q;
  assign adel      = in_idle & req & ~legal & ~we;
  assign ades      = in_idle & req & ~legal & we;
  assign bus_req   = in_bus;
  assign bus_we    = in_bus & we_q;
  assign bus_addr  = in_bus ? addr_q[31:2] : '0;
  assign bus_be    = in_bus ? be_q : '0;
  assign bus_wdata = in_bus ? wdata_q : '0;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl, TIMEOUT overridden to 4.
module tb_dm_ctrl;

  localparam int unsigned TO = 4;
  localparam logic [1:0] BW = 2'b00;
  localparam logic [1:0] BH = 2'b01;
  localparam logic [1:0] BB = 2'b10;

  logic        clk = 1'b0;
  logic        rst, req, we, ld_unsigned;
  logic [1:0]  besel;
  logic [31:0] addr, wdata;
  logic        stall, done, adel, ades, bus_err;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;

  dm_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .besel(besel),
    .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .adel(adel), .ades(ades),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [29:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_exp_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int unsigned txn_seen = 0;
  int unsigned txn_exp  = 0;
  logic        req_prev = 1'b0;

  function automatic logic [3:0] m_be(input logic [1:0] bs, input logic [31:0] a);
    case (bs)
      BW: return 4'hF;
      BH: return a[1] ? 4'hC : 4'h3;
      BB: case (a[1:0])
            2'd0: return 4'h1;
            2'd1: return 4'h2;
            2'd2: return 4'h4;
            default: return 4'h8;
          endcase
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] bs, input logic [31:0] w);
    case (bs)
      BB: return {w[7:0], w[7:0], w[7:0], w[7:0]};
      BH: return {w[15:0], w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] bs, input logic [31:0] a,
                                       input logic [31:0] r, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = r[7:0];
      2'd1: b = r[15:8];
      2'd2: b = r[23:16];
      default: b = r[31:24];
    endcase
    h = a[1] ? r[31:16] : r[15:0];
    case (bs)
      BB: return u ? {24'h0, b} : {{24{b[7]}}, b};
      BH: return u ? {16'h0, h} : {{16{h[15]}}, h};
      default: return r;
    endcase
  endfunction

  // Scoreboard side: compares bus fields at the ack cycle and results at done.
  always @(negedge clk) begin
    bus_exp_t  be_e;
    done_exp_t dn_e;
    if (bus_req && !req_prev) txn_seen++;
    req_prev = bus_req;
    if (bus_req && bus_ack) begin
      if (bus_q.size() == 0) chk("bus_unexp", 32'd1, 32'd0);
      else begin
        be_e = bus_q.pop_front();
        chk("bus_we",    {31'd0, bus_we}, {31'd0, be_e.we});
        chk("bus_addr",  {2'd0, bus_addr}, {2'd0, be_e.a});
        chk("bus_be",    {28'd0, bus_be}, {28'd0, be_e.be});
        chk("bus_wdata", bus_wdata, be_e.wd);
      end
    end
    if (done) begin
      if (done_q.size() == 0) chk("done_unexp", 32'd1, 32'd0);
      else begin
        dn_e = done_q.pop_front();
        chk("rdata",   rdata, dn_e.rd);
        chk("bus_err", {31'd0, bus_err}, {31'd0, dn_e.err});
      end
    end
  end

  // Called in the slot #1 after a rising edge; returns in the same kind of slot.
  // ackw >= 0: ack driven in BUS cycle ackw+1; ackw < 0: never ack.
  task automatic access(input logic w, input logic [1:0] bs, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ackw, input string tag);
    int expd;
    int cyc;
    bit seen;
    bus_exp_t  be_e;
    done_exp_t dn_e;
    expd = (ackw >= 0) ? ackw + 2 : int'(TO) + 1;
    cyc  = 0;
    seen = 0;
    txn_exp++;
    if (ackw >= 0) begin
      be_e.we = w; be_e.a = a[31:2]; be_e.be = m_be(bs, a); be_e.wd = m_wd(bs, wd);
      bus_q.push_back(be_e);
    end
    dn_e.rd  = (ackw < 0 || w) ? 32'h0 : m_rd(bs, a, rd, u);
    dn_e.err = (ackw < 0);
    done_q.push_back(dn_e);
    req = 1'b1; we = w; besel = bs; ld_unsigned = u; addr = a; wdata = wd;
    bus_rdata = rd; bus_ack = 1'b0;
    while (!seen && cyc <= 300) begin
      @(negedge clk);
      if (done) begin
        chk({tag, "_lat"}, cyc, expd);
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        seen = 1;
      end else begin
        chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, "_busreq"}, {31'd0, bus_req}, (cyc >= 1) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
      bus_ack = (ackw >= 0 && cyc == ackw + 1);
    end
    if (!seen) chk({tag, "_no_done"}, 32'd0, 32'd1);
    req = 1'b0;
    bus_ack = 1'b0;
  endtask

  task automatic bad_access(input logic w, input logic [1:0] bs, input logic [31:0] a,
                            input string tag);
    req = 1'b1; we = w; besel = bs; ld_unsigned = 1'b0; addr = a; wdata = 32'h0;
    @(negedge clk);
    chk({tag, "_adel"},  {31'd0, adel},  {31'd0, ~w});
    chk({tag, "_ades"},  {31'd0, ades},  {31'd0, w});
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_busreq"}, {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk({tag, "_busreq2"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_done2"},   {31'd0, done},    32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stall"},  {31'd0, stall},   32'd0);
    chk({tag, "_done"},   {31'd0, done},    32'd0);
    chk({tag, "_rdata"},  rdata,            32'd0);
    chk({tag, "_ad"},     {30'd0, adel, ades}, 32'd0);
    chk({tag, "_err"},    {31'd0, bus_err}, 32'd0);
    chk({tag, "_breq"},   {30'd0, bus_req, bus_we}, 32'd0);
    chk({tag, "_baddr"},  {2'd0, bus_addr}, 32'd0);
    chk({tag, "_bbe"},    {28'd0, bus_be},  32'd0);
    chk({tag, "_bwd"},    bus_wdata,        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; besel = BW; ld_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    access(1'b1, BB, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, "sb");
    access(1'b0, BH, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, "lhs");
    access(1'b0, BH, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 2, "lhu");
    access(1'b0, BB, 1'b0, 32'h0000_0101, 32'h0, 32'h0000_8000, 0, "lbs");
    access(1'b0, BB, 1'b1, 32'h0000_0103, 32'h0, 32'hF000_0000, 0, "lbu");
    access(1'b1, BH, 1'b0, 32'h0000_0002, 32'h1234_BEEF, 32'h0, 0, "sh");
    access(1'b0, BW, 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 3, "lw");
`ifdef DM_ALIGN_CHECK_EN
    bad_access(1'b0, BW, 32'h0000_3001, "mis");
`else
    access(1'b0, BW, 1'b0, 32'h0000_3001, 32'h0, 32'h1234_5678, 0, "mis");
`endif
    bad_access(1'b1, 2'b11, 32'h0000_0040, "badsel");
    bad_access(1'b0, 2'b11, 32'h0000_0044, "badsel_ld");

    // Watchdog expiry: no ack ever
    access(1'b0, BW, 1'b0, 32'h0000_0050, 32'h0, 32'h0, -1, "wd");

    // Back-to-back, zero-wait ack
    access(1'b1, BB, 1'b0, 32'h0000_0070, 32'h0000_005A, 32'h0, 0, "b2b_st");
    access(1'b0, BB, 1'b0, 32'h0000_0070, 32'h0, 32'h0000_005A, 0, "b2b_ld");

    // Reset in the middle of a transaction, late ack must be ignored
    txn_exp++;
    req = 1'b1; we = 1'b0; besel = BW; addr = 32'h0000_0060;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0; bus_ack = 1'b1;
    @(negedge clk);
    chk_idle("rst_mid");
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("late_ack_done", {31'd0, done}, 32'd0);
    end
    bus_ack = 1'b0;
    @(posedge clk); #1;

    chk("txn_count", txn_seen, txn_exp);
    chk("sb_empty", bus_q.size() + done_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
